// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: datapath widths, the fetch queue
// entry layout and the canonical NOP encoding.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: entries are reserved in fetch order at the tail,
// filled in order as responses return, and popped from the head once filled.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    reserve_i,
    input  logic [XLEN-1:0]         reserve_pc_i,
    input  logic                    fill_i,
    input  logic [INSTR_W-1:0]      fill_instr_i,
    input  logic                    pop_i,
    output fetch_entry_t            head_o,
    output logic                    head_valid_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] tail_q, tail_d;

    logic [AW-1:0] tail_idx;
    logic [AW-1:0] fill_idx;

    fetch_entry_t [DEPTH-1:0] entries;

    assign tail_idx = tail_q[AW-1:0];
    assign fill_idx = fill_q[AW-1:0];

    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
        end else begin
            if (reserve_i) tail_d = tail_q + CW'(1);
            if (fill_i)    fill_d = fill_q + CW'(1);
            if (pop_i)     head_d = head_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fetch_entry_t entry_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (flush_i) begin
                entry_q.filled <= 1'b0;
            end else begin
                // A reserved slot is always free, so it never collides with the fill slot.
                if (reserve_i && (tail_idx == AW'(gi))) begin
                    entry_q.pc     <= reserve_pc_i;
                    entry_q.instr  <= NOP_INSTR;
                    entry_q.filled <= 1'b0;
                end
                if (fill_i && (fill_idx == AW'(gi))) begin
                    entry_q.instr  <= fill_instr_i;
                    entry_q.filled <= 1'b1;
                end
            end
        end

        assign entries[gi] = entry_q;
    end

    assign count_o      = tail_q - head_q;
    assign head_o       = entries[head_q[AW-1:0]];
    assign head_valid_o = (count_o != '0) && head_o.filled;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_o <= CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches from pc, tracks in-flight
// responses, discards stale ones after a redirect and feeds ID from the queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_addr,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int DROP_W = 16;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    logic          q_head_valid;

    logic issue;
    logic rsp_any;
    logic rsp_drop;
    logic rsp_fill;
    logic pop;

    // Every queue slot is either filled or reserved for an in-flight fetch,
    // so queue occupancy already equals queued + inflight.
    assign imem_req  = reset && !redirect && (q_count < CW'(DEPTH));
    assign imem_addr = pc_q;

    assign issue    = imem_req && imem_gnt;
    assign rsp_any  = imem_rvalid && ((drop_q != '0) || (inflight_q != '0));
    assign rsp_drop = imem_rvalid && (drop_q != '0);
    assign rsp_fill = imem_rvalid && (drop_q == '0) && (inflight_q != '0) && !redirect;
    assign pop      = q_head_valid && out_ready && !redirect;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect) begin
            // A response landing this cycle is consumed here, so it is not owed a drop.
            pc_d       = word_align(redirect_addr);
            inflight_d = '0;
            drop_d     = drop_q + DROP_W'(inflight_q) - DROP_W'(rsp_any);
        end else begin
            if (issue)    pc_d   = pc_q + XLEN'(4);
            if (rsp_drop) drop_d = drop_q - DROP_W'(1);
            inflight_d = inflight_q + CW'(issue) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= word_align(RESET_ADDR);
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (reset),
        .flush_i      (redirect),
        .reserve_i    (issue),
        .reserve_pc_i (pc_q),
        .fill_i       (rsp_fill),
        .fill_instr_i (imem_rdata),
        .pop_i        (pop),
        .head_o       (q_head),
        .head_valid_o (q_head_valid),
        .count_o      (q_count)
    );

    assign out_valid = q_head_valid;
    assign out_instr = q_head_valid ? q_head.instr : '0;
    assign out_pc    = q_head_valid ? q_head.pc    : '0;

    a_inflight_le_count: assert property (@(posedge clk) disable iff (!reset)
        inflight_q <= q_count);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory with random latency and
// an epoch-based reference model of the expected fetch stream.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        int          pre;
        int          lat;
        logic        rdy;
        int          nredir;
        logic [31:0] target;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } rvec_t;

    mreq_t       mem_q[$];
    logic [31:0] popped[$];
    int lat_min = 1, lat_max = 1;
    int checks = 0, errors = 0;
    int cyc = 0, epoch = 0;
    int grants = 0, total_pops = 0, first_pop_cyc = -1;
    bit verbose = 1'b1;

    // Reference model: the output stream is consecutive words from the last
    // reset/redirect target; only responses from the current epoch count.
    logic [31:0] m_pc = RESET_ADDR;
    logic [31:0] m_out_pc = RESET_ADDR;
    int m_occ = 0, m_rdy = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        mreq_t r, nr;
        logic deliver, exp_req, exp_valid, m_issue, d_issue, pop, rst_s, redir_s;
        logic [31:0] tgt_s, addr_s;
        int c0, e0;
        deliver = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = deliver;
        imem_rdata  = deliver ? mem_word(mem_q[0].addr) : 32'h0;
        #1;
        exp_req = 1'b0;
        exp_valid = 1'b0;
        if (!reset) begin
            check1("rst_imem_req", imem_req, 1'b0);
            check1("rst_out_valid", out_valid, 1'b0);
            check32("rst_imem_addr", imem_addr, RESET_ADDR);
            check32("rst_out_pc", out_pc, 32'h0);
            check32("rst_out_instr", out_instr, 32'h0);
        end else begin
            exp_req   = (m_occ < DEPTH) && !redirect;
            exp_valid = (m_rdy > 0);
            check1("imem_req", imem_req, exp_req);
            check32("imem_addr", imem_addr, m_pc);
            check1("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check32("out_pc", out_pc, m_out_pc);
                check32("out_instr", out_instr, mem_word(m_out_pc));
            end
        end
        m_issue = reset && exp_req && imem_gnt;
        d_issue = imem_req && imem_gnt;
        addr_s  = imem_addr;
        pop     = reset && exp_valid && out_ready && !redirect;
        rst_s   = reset;
        redir_s = redirect;
        tgt_s   = redirect_addr;
        c0 = cyc;
        e0 = epoch;
        @(posedge clk);
        cyc++;
        if (d_issue) grants++;
        r.addr = 32'h0; r.epoch = -1; r.due = 0;
        if (deliver) r = mem_q.pop_front();
        if (!rst_s) begin
            epoch++;
            m_pc = RESET_ADDR; m_out_pc = RESET_ADDR; m_occ = 0; m_rdy = 0;
        end else if (redir_s) begin
            epoch++;
            m_pc = tgt_s & 32'hFFFF_FFFC; m_out_pc = m_pc; m_occ = 0; m_rdy = 0;
        end else begin
            if (deliver && r.epoch == epoch) m_rdy++;
            if (m_issue) begin
                m_pc += 32'd4;
                m_occ++;
            end
            if (pop) begin
                if (verbose) $display("pop  pc=%h instr=%h cycle=%0d", m_out_pc, mem_word(m_out_pc), c0);
                if (first_pop_cyc < 0) first_pop_cyc = c0;
                popped.push_back(m_out_pc);
                total_pops++;
                m_out_pc += 32'd4;
                m_occ--;
                m_rdy--;
            end
        end
        if (d_issue) begin
            nr.addr  = addr_s;
            nr.epoch = e0;
            nr.due   = c0 + $urandom_range(lat_max, lat_min);
            mem_q.push_back(nr);
        end
        #1;
    endtask

    task automatic run(input int n, input logic gnt, input logic rdy);
        imem_gnt = gnt;
        out_ready = rdy;
        redirect = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain_and_reset();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && mem_q.size() > 0; i++) cycle();
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    task automatic check_popped(input string name, input int idx, input logic [31:0] exp);
        if (popped.size() > idx) check32(name, popped[idx], exp);
        else check32(name, 32'hXXXX_XXXX, exp);
    endtask

    logic [31:0] exp_seq[5];
    rvec_t       vecs[6];
    int          start;

    initial begin
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        vecs[0] = '{2, 4, 1'b0, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[1] = '{3, 1, 1'b1, 1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
        vecs[2] = '{1, 2, 1'b1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{0, 3, 1'b1, 1, 32'h0000_1236, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};
        vecs[4] = '{3, 3, 1'b0, 2, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};
        vecs[5] = '{4, 2, 1'b1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEC, 32'hDEAD_BEF0, 32'hDEAD_BEF4};

        #1 reset = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;

        // Streaming: one instruction per cycle once the pipe has filled.
        lat_min = 1; lat_max = 1;
        popped.delete();
        first_pop_cyc = -1;
        start = cyc;
        run(8, 1'b1, 1'b1);
        check32("stream_first_pop_latency", 32'(first_pop_cyc - start), 32'd2);
        check32("stream_pop_count", 32'(popped.size()), 32'd6);
        for (int i = 0; i < 4; i++) check_popped("stream_pc", i, exp_seq[i]);

        // Backpressure: queue fills to DEPTH, then drains in order.
        drain_and_reset();
        grants = 0;
        run(10, 1'b1, 1'b0);
        check32("stall_grants", 32'(grants), 32'(DEPTH));
        check1("stall_req_low", imem_req, 1'b0);
        check32("stall_out_pc", out_pc, 32'h0);
        popped.delete();
        run(12, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) check_popped("stall_release_pc", i, exp_seq[i]);

        // Redirect scenarios from the vector table.
        for (int v = 0; v < 6; v++) begin
            drain_and_reset();
            lat_min = vecs[v].lat; lat_max = vecs[v].lat;
            run(vecs[v].pre, 1'b1, 1'b0);
            popped.delete();
            $display("vec %0d: redirect to %h after %0d grants", v, vecs[v].target, vecs[v].pre);
            redirect = 1'b1;
            redirect_addr = vecs[v].target;
            out_ready = vecs[v].rdy;
            imem_gnt = 1'b1;
            repeat (vecs[v].nredir) cycle();
            redirect = 1'b0;
            run(25, 1'b1, 1'b1);
            check_popped("redir_pc0", 0, vecs[v].exp0);
            check_popped("redir_pc1", 1, vecs[v].exp1);
            check_popped("redir_pc2", 2, vecs[v].exp2);
        end

        // Reset with three fetches outstanding; their late responses must vanish.
        drain_and_reset();
        lat_min = 5; lat_max = 5;
        run(3, 1'b1, 1'b0);
        reset = 1'b0;
        imem_gnt = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        run(6, 1'b0, 1'b1);
        check1("late_rsp_no_valid", out_valid, 1'b0);
        lat_min = 1; lat_max = 1;
        popped.delete();
        run(10, 1'b1, 1'b1);
        check_popped("after_reset_first_pc", 0, RESET_ADDR);

        // Randomised traffic against the reference model.
        drain_and_reset();
        verbose = 1'b0;
        lat_min = 1; lat_max = 4;
        start = total_pops;
        for (int i = 0; i < 2000; i++) begin
            imem_gnt      = ($urandom_range(9, 0) < 7);
            out_ready     = ($urandom_range(9, 0) < 7);
            redirect      = ($urandom_range(31, 0) == 0);
            redirect_addr = $urandom();
            cycle();
        end
        redirect = 1'b0;
        $display("random phase: %0d instructions delivered", total_pops - start);
        check1("random_progress", (total_pops - start) >= 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction queue entries, a power of two with a minimum of 2.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 redirect  in  1  SHALL signal a taken branch or jump from EX, meaning flush and refetch.
REQ-006 redirect_addr  in  32  SHALL be the new fetch target; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req  out  1  SHALL be the fetch request valid.
REQ-008 imem_addr  out  32  SHALL be the word-aligned fetch address.
REQ-009 imem_gnt  in  1  SHALL indicate the request is accepted this cycle.
REQ-010 imem_rvalid  in  1  SHALL indicate returned instruction data; responses arrive in order, 1 or more cycles after grant.
REQ-011 imem_rdata  in  32  SHALL be the instruction word.
REQ-012 out_valid  out  1  SHALL indicate an instruction is available to ID.
REQ-013 out_ready  in  1  SHALL indicate ID accepts the instruction this cycle.
REQ-014 out_instr  out  32  SHALL be the instruction word for ID.
REQ-015 out_pc  out  32  SHALL be the address of out_instr.

Function
REQ-016 pc SHALL drive imem_addr directly, and pc[1:0] SHALL always be 0.
REQ-017 imem_req SHALL be 1 iff (queued + inflight) < DEPTH and redirect==0.
REQ-018 On imem_req && imem_gnt, the block SHALL reserve the tail entry with out_pc=pc and mark it unfilled, then set pc <= pc+4.
REQ-019 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL give 0.
REQ-020 On imem_rvalid, the data SHALL fill the oldest unfilled reserved entry, unless the response is being dropped per REQ-024.
REQ-021 out_valid SHALL be 1 iff the head entry is filled; the minimum latency is rvalid at cycle N giving out_valid at N+1.
REQ-022 A pop SHALL occur on out_valid && out_ready, and the next filled entry SHALL be presented the following cycle.
REQ-023 While out_valid && !out_ready and no redirect, out_instr and out_pc SHALL hold stable.
REQ-024 On redirect, the block SHALL: clear all entries; load drop_cnt with the in-flight count (granted but not returned, excluding any response arriving in the same cycle, which is discarded); set pc <= {redirect_addr[31:2],2'b00}.
REQ-025 While drop_cnt>0, each imem_rvalid SHALL be discarded and SHALL decrement drop_cnt.
REQ-026 Redirect SHALL take priority over a simultaneous grant, pop, or fill in the same cycle.
REQ-027 out_valid SHALL be 0 in the cycle after a redirect.
REQ-028 Issue, fill and pop SHALL be allowed in the same cycle, both at full and at empty.
REQ-029 imem_rvalid with no in-flight request SHALL be ignored.
REQ-030 A back-to-back redirect SHALL re-apply REQ-024, adding the prior drop_cnt to the newly computed in-flight count.

Reset
REQ-031 While reset==0, the block SHALL hold: pc=RESET_ADDR, queue empty, inflight=0, drop_cnt=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-032 Assertion of reset mid-operation SHALL abandon all in-flight requests, and no stale response SHALL be presented after release.
REQ-033 The first imem_req SHALL rise in the first cycle after reset deasserts.

Structure
REQ-034 Package cpu_pkg SHALL hold the XLEN=32 and INSTR_W=32 constants, the fetch_entry_t struct {pc, instr, filled}, and the NOP encoding 32'h0000_0013.
REQ-035 Sub-module fetch_queue SHALL implement the circular buffer: DEPTH entries, head/tail pointers with wrap bit, reserve/fill/pop/flush ports.
REQ-036 The fetch_unit top SHALL own pc, the inflight counter, drop_cnt and the request logic.

Verification
REQ-037 Reset release, imem_gnt=1 and 1-cycle rvalid, out_ready=1 -> out_pc sequence 0,4,8,12 is presented one per cycle after fill-up.
REQ-038 out_ready=0 for 10 cycles -> exactly DEPTH=4 grants occur, imem_req drops, and out_pc=0 stays stable; on release, pcs 0,4,8,12,16 are presented in order.
REQ-039 With 2 requests in flight, redirect to 32'h0000_0100 -> both stale responses are dropped, and the next out_pc is 32'h100 with the data from address 0x100.
REQ-040 Redirect in the same cycle as rvalid and out_ready -> no pop is observed, the response is discarded, and the refetch starts from the redirect target.
REQ-041 pc=32'hFFFF_FFF8 via redirect, free-running -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-042 Reset asserted with 3 requests in flight, late responses arriving after release -> the responses are ignored and the first out_pc is RESET_ADDR.
